rr_burst_arbiter: RTL and testbench

//   Round-robin arbiter with burst hold: once a client is granted it keeps the grant for
//   up to MAX_BURST accepted beats, or until it signals last or drops request. Fronts a

---
 rtl/rr_burst_arbiter.sv | 147 ++++++++++++++
 tb/tb_rr_burst_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst hold.
// A granted client keeps the bus for up to MAX_BURST accepted beats. The grant
// also ends when the client flags last or drops its request. After a grant
// ends, the client just served gets the lowest priority in the next pick.
// Handshake: a beat is accepted on a rising edge where the granted client is
// requesting and stall is low. While stall is high, nothing moves: grant,
// burst_count and the rotation pointer all hold.
// busy is the GRANT state of the FSM, so it doubles as the state debug view.
module rr_burst_arbiter #(
  parameter int CLIENTS   = 4,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] request,
  input  logic [CLIENTS-1:0] last,
  input  logic               stall,
  output logic [CLIENTS-1:0] grant,
  output logic               busy,
  output logic [CNT_W-1:0]   burst_count
);

  localparam int PTR_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, next_state;
  logic [PTR_W-1:0]   ptr, next_ptr;
  logic [CLIENTS-1:0] next_grant;
  logic [CNT_W-1:0]   next_count;

  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   rot_ptr;
  logic [PTR_W-1:0]   arb_base;
  logic [CLIENTS-1:0] pick_grant;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;
  logic               found;

  logic req_g;
  logic last_g;
  logic at_limit;
  logic beat;
  logic burst_end;

  // Index of the currently granted client (grant is one-hot or zero)
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (grant[i]) g_idx = PTR_W'(i);
    end
  end

  // Pointer value after the current burst ends, and the base used for arbitration
  always_comb begin
    rot_ptr  = (g_idx == PTR_W'(CLIENTS - 1)) ? '0 : g_idx + PTR_W'(1);
    arb_base = (state == GRANT) ? rot_ptr : ptr;
  end

  // Rotating priority search starting at arb_base
  always_comb begin
    pick_grant = '0;
    found      = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      scan_sum = {1'b0, arb_base} + (PTR_W + 1)'(k);
      if (scan_sum >= (PTR_W + 1)'(CLIENTS)) scan_sum = scan_sum - (PTR_W + 1)'(CLIENTS);
      scan_idx = scan_sum[PTR_W-1:0];
      if (!found && request[scan_idx]) begin
        pick_grant[scan_idx] = 1'b1;
        found                = 1'b1;
      end
    end
  end

  // Beat acceptance and end-of-burst detection for the granted client
  always_comb begin
    req_g     = |(grant & request);
    last_g    = |(grant & last);
    at_limit  = (burst_count == CNT_W'(MAX_BURST - 1));
    beat      = req_g && !stall;
    burst_end = (beat && (last_g || at_limit)) || (busy && !req_g && !stall);
  end

  // Next-state, next-grant, counter and pointer update
  always_comb begin
    next_state = state;
    next_grant = grant;
    next_count = burst_count;
    next_ptr   = ptr;
    case (state)
      IDLE: begin
        next_grant = '0;
        next_count = '0;
        if (!stall && |request) begin
          next_state = GRANT;
          next_grant = pick_grant;
        end
      end
      GRANT: begin
        if (stall) begin
          next_state = GRANT;
        end else if (burst_end) begin
          next_ptr   = rot_ptr;
          next_count = '0;
          if (|request) begin
            next_state = GRANT;
            next_grant = pick_grant;
          end else begin
            next_state = IDLE;
            next_grant = '0;
          end
        end else if (beat) begin
          next_count = burst_count + CNT_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_grant = '0;
        next_count = '0;
      end
    endcase
  end

  // State, grant, counter and pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      burst_count <= '0;
      ptr         <= '0;
    end else begin
      state       <= next_state;
      grant       <= next_grant;
      burst_count <= next_count;
      ptr         <= next_ptr;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter with CLIENTS=4 and MAX_BURST=4.
// Inputs are driven on the falling edge. Outputs are sampled one falling edge
// later, which is after the rising edge that consumed those inputs.
module tb_rr_burst_arbiter;

  localparam int CLIENTS   = 4;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam int NVEC      = 31;
  localparam int NRAND     = 3000;

  logic               clock;
  logic               reset;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] last;
  logic               stall;
  logic [CLIENTS-1:0] grant;
  logic               busy;
  logic [CNT_W-1:0]   burst_count;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lst;
    logic       stl;
    logic [3:0] g;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[NVEC];

  rr_burst_arbiter #(
    .CLIENTS  (CLIENTS),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .request    (request),
    .last       (last),
    .stall      (stall),
    .grant      (grant),
    .busy       (busy),
    .burst_count(burst_count)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] rq, input logic [3:0] ls,
                         input logic st, input logic [3:0] g, input logic [2:0] c);
    vecs[i].req = rq;
    vecs[i].lst = ls;
    vecs[i].stl = st;
    vecs[i].g   = g;
    vecs[i].cnt = c;
  endtask

  task automatic drive(input logic [3:0] rq, input logic [3:0] ls, input logic st);
    request = rq;
    last    = ls;
    stall   = st;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [3:0] r_req, r_last;
  logic       r_stall;
  logic [3:0] prev_grant;
  logic [2:0] prev_cnt;
  logic       new_burst;
  int         wait_bursts[CLIENTS];

  initial begin
    checks   = 0;
    failures = 0;

    // Expected output after each rising edge, hand-computed (ptr starts at 0)
    // Sole requester: 4 beats (count 0..3), then regranted
    set_vec(0,  4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd0);
    set_vec(1,  4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd1);
    set_vec(2,  4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd2);
    set_vec(3,  4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd3);
    set_vec(4,  4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd0);
    // All requesting, last on every 2nd beat: 0001 -> 0010 -> 0100 -> 1000 -> 0001
    set_vec(5,  4'b1111, 4'b0000, 1'b0, 4'b0001, 3'd1);
    set_vec(6,  4'b1111, 4'b1111, 1'b0, 4'b0010, 3'd0);
    set_vec(7,  4'b1111, 4'b0000, 1'b0, 4'b0010, 3'd1);
    set_vec(8,  4'b1111, 4'b1111, 1'b0, 4'b0100, 3'd0);
    set_vec(9,  4'b1111, 4'b0000, 1'b0, 4'b0100, 3'd1);
    set_vec(10, 4'b1111, 4'b1111, 1'b0, 4'b1000, 3'd0);
    set_vec(11, 4'b1111, 4'b0000, 1'b0, 4'b1000, 3'd1);
    set_vec(12, 4'b1111, 4'b1111, 1'b0, 4'b0001, 3'd0);
    // Reach grant=0010 count=2, then stall 5 cycles with last high (ignored)
    set_vec(13, 4'b1111, 4'b1111, 1'b0, 4'b0010, 3'd0);
    set_vec(14, 4'b1111, 4'b0000, 1'b0, 4'b0010, 3'd1);
    set_vec(15, 4'b1111, 4'b0000, 1'b0, 4'b0010, 3'd2);
    set_vec(16, 4'b1111, 4'b1111, 1'b1, 4'b0010, 3'd2);
    set_vec(17, 4'b1111, 4'b1111, 1'b1, 4'b0010, 3'd2);
    set_vec(18, 4'b1111, 4'b1111, 1'b1, 4'b0010, 3'd2);
    set_vec(19, 4'b1111, 4'b1111, 1'b1, 4'b0010, 3'd2);
    set_vec(20, 4'b1111, 4'b1111, 1'b1, 4'b0010, 3'd2);
    set_vec(21, 4'b1111, 4'b0000, 1'b0, 4'b0010, 3'd3);
    set_vec(22, 4'b1111, 4'b0000, 1'b0, 4'b0100, 3'd0);
    // Granted client 2 drops its request: end with no beat, next grant is 1000
    set_vec(23, 4'b1001, 4'b0000, 1'b0, 4'b1000, 3'd0);
    // Nobody requests: back to idle; a stalled request in idle is not granted
    set_vec(24, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0);
    set_vec(25, 4'b0100, 4'b0000, 1'b1, 4'b0000, 3'd0);
    set_vec(26, 4'b0100, 4'b0000, 1'b0, 4'b0100, 3'd0);
    set_vec(27, 4'b0100, 4'b0100, 1'b0, 4'b0100, 3'd0);
    set_vec(28, 4'b1010, 4'b0000, 1'b0, 4'b1000, 3'd0);
    set_vec(29, 4'b1000, 4'b0000, 1'b0, 4'b1000, 3'd1);
    set_vec(30, 4'b1000, 4'b0000, 1'b0, 4'b1000, 3'd2);

    // Reset phase
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_count", burst_count, 0);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].req, vecs[i].lst, vecs[i].stl);
      step();
      check($sformatf("vec%0d_grant", i), grant, vecs[i].g);
      check($sformatf("vec%0d_count", i), burst_count, vecs[i].cnt);
      check($sformatf("vec%0d_busy", i), busy, |vecs[i].g);
    end

    // Asynchronous reset mid-burst (grant=1000, count=2)
    #2 reset = 1'b1;
    #1;
    check("async_reset_grant", grant, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_count", burst_count, 0);
    drive(4'b1111, 4'b0000, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check("post_reset_grant", grant, 4'b0001);
    check("post_reset_count", burst_count, 0);

    // Random phase: invariants, stall freeze and bounded waiting
    prev_grant = grant;
    prev_cnt   = burst_count;
    for (int c = 0; c < CLIENTS; c++) wait_bursts[c] = 0;
    for (int n = 0; n < NRAND; n++) begin
      for (int c = 0; c < CLIENTS; c++) begin
        r_req[c]  = ($urandom_range(0, 99) < 80);
        r_last[c] = ($urandom_range(0, 99) < 25);
      end
      r_stall = ($urandom_range(0, 99) < 20);
      drive(r_req, r_last, r_stall);
      step();
      check("rand_onehot0", $onehot0(grant), 1);
      check("rand_busy", busy, |grant);
      check("rand_count_max", burst_count <= 3'(MAX_BURST - 1), 1);
      if (grant != prev_grant && grant != 0)
        check("rand_grant_had_req", (grant & r_req) == grant, 1);
      if (r_stall && prev_grant != 0) begin
        check("rand_stall_grant", grant, prev_grant);
        check("rand_stall_count", burst_count, prev_cnt);
      end
      new_burst = (grant != 0) && ((grant != prev_grant) || (burst_count == 0 && prev_cnt != 0));
      for (int c = 0; c < CLIENTS; c++) begin
        if (!r_req[c] || grant[c]) wait_bursts[c] = 0;
        else if (new_burst) wait_bursts[c]++;
        check($sformatf("rand_starve%0d", c), wait_bursts[c] <= CLIENTS - 1, 1);
      end
      prev_grant = grant;
      prev_cnt   = burst_count;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
